// File: rtl/gpio_ctrl.sv
// gpio_ctrl: GPIO with direction, synchronised inputs, set/clear writes and edge interrupts.
// Optional per-pin input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl #(
    parameter int NUM_PINS        = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    input  logic                we,
    input  logic                re,
    input  logic [3:0]          byte_mask,
    output logic [31:0]         rdata,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);
    localparam int N = NUM_PINS;

    logic [N-1:0] r_out, r_dir, r_ie, r_edge, r_status, r_s_d;
    logic [N-1:0] w_s, w_wd, w_evt, w_w1c;
    logic [SYNC_STAGES-1:0][N-1:0] r_sync;
    logic [31:0] w_mask32, w_rd;
    logic w_wr, w_unused;

    assign w_mask32 = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
    assign w_wd     = wdata[N-1:0] & w_mask32[N-1:0];
    assign w_wr     = sel && we;
    assign w_w1c    = (w_wr && addr[4:2] == 3'd5) ? w_wd : '0;
    assign w_evt    = (r_edge & w_s & ~r_s_d) | (~r_edge & ~w_s & r_s_d);
    assign w_unused = ^{addr[1:0], wdata, w_mask32};

    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_status & r_ie);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_ie     <= '0;
            r_edge   <= '0;
            r_status <= '0;
            r_sync   <= '0;
            r_s_d    <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_s_d    <= w_s;
            // a new event on a bit being cleared in the same cycle keeps it set
            r_status <= (r_status & ~w_w1c) | w_evt;
            if (w_wr) begin
                case (addr[4:2])
                    3'd0:    r_out  <= (r_out & ~w_mask32[N-1:0]) | w_wd;
                    3'd1:    r_dir  <= (r_dir & ~w_mask32[N-1:0]) | w_wd;
                    3'd3:    r_ie   <= (r_ie & ~w_mask32[N-1:0]) | w_wd;
                    3'd4:    r_edge <= (r_edge & ~w_mask32[N-1:0]) | w_wd;
                    3'd6:    r_out  <= r_out | w_wd;
                    3'd7:    r_out  <= r_out & ~w_wd;
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [N-1:0][CW-1:0] r_cnt;
    logic [N-1:0]         r_db;

    // the debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_db  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_sync[SYNC_STAGES-1][i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_s = r_db;
`else
    assign w_s = r_sync[SYNC_STAGES-1];
`endif

    always_comb begin
        w_rd = '0;
        case (addr[4:2])
            3'd0:    w_rd = 32'(r_out);
            3'd1:    w_rd = 32'(r_dir);
            3'd2:    w_rd = 32'(w_s);
            3'd3:    w_rd = 32'(r_ie);
            3'd4:    w_rd = 32'(r_edge);
            3'd5:    w_rd = 32'(r_status);
            default: w_rd = '0;
        endcase
        rdata = (sel && re) ? w_rd : '0;
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed and randomized checks of gpio_ctrl against a pin-history reference model.
module tb_gpio_ctrl;
    localparam int SYNC = 2;

    logic        clk = 0, rst = 0, sel = 0, we = 0, re = 0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0, gpio_in = '0;
    logic [3:0]  byte_mask = '0;
    logic [31:0] rdata, gpio_out, gpio_oe;
    logic        irq;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    gpio_ctrl #(.NUM_PINS(32), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .byte_mask(byte_mask), .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    // Reference model: registers plus a history of pin values seen at each edge.
    // IN after an edge is the pin value sampled SYNC-1 edges earlier; an event
    // reaches STATUS one edge after that value becomes visible.
    logic [31:0] m_out, m_dir, m_ie, m_edge, m_status;
    logic [7:0][31:0] m_hist;
    logic [31:0] m_bm, m_d, m_ev, m_clr;

    assign m_bm  = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
    assign m_d   = wdata & m_bm;
    assign m_ev  = (m_edge & m_hist[SYNC-1] & ~m_hist[SYNC]) | (~m_edge & ~m_hist[SYNC-1] & m_hist[SYNC]);
    assign m_clr = (sel && we && addr[4:2] == 3'd5) ? m_d : 32'h0;

    always @(posedge clk) begin
        if (!rst) begin
            m_out <= 0; m_dir <= 0; m_ie <= 0; m_edge <= 0; m_status <= 0; m_hist <= '0;
        end else begin
            m_hist   <= {m_hist[6:0], gpio_in};
            m_status <= (m_status & ~m_clr) | m_ev;
            if (sel && we) begin
                case (addr[4:2])
                    3'd0: m_out  <= (m_out & ~m_bm) | m_d;
                    3'd1: m_dir  <= (m_dir & ~m_bm) | m_d;
                    3'd3: m_ie   <= (m_ie & ~m_bm) | m_d;
                    3'd4: m_edge <= (m_edge & ~m_bm) | m_d;
                    3'd6: m_out  <= m_out | m_d;
                    3'd7: m_out  <= m_out & ~m_d;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] mdl_read(input logic [2:0] r);
        case (r)
            3'd0: return m_out;
            3'd1: return m_dir;
            3'd2: return m_hist[SYNC-1];
            3'd3: return m_ie;
            3'd4: return m_edge;
            3'd5: return m_status;
            default: return 32'h0;
        endcase
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        sel = 1; we = 1; addr = a; wdata = d; byte_mask = m;
        @(posedge clk);
        #1;
        sel = 0; we = 0; byte_mask = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        sel = 1; re = 1; addr = a;
        #1;
        d = rdata;
        sel = 0; re = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 0; gpio_in = 0;
        cycles(3);
        rst = 1;
        cycles(1);
        n_checks++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_out got %h want 0", gpio_out); end
        n_checks++; if (gpio_oe !== 32'h0) begin n_fail++; $display("FAIL reset_oe got %h want 0", gpio_oe); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        for (int a = 0; a < 8; a++) begin
            rd(5'(a * 4), v);
            n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got %h want 0", a, v); end
        end
    endtask

    task automatic test_byte_mask;
        logic [31:0] v;
        wr(5'h00, 32'hA5A5_A5A5, 4'b0011);
        rd(5'h00, v);
        n_checks++; if (v !== 32'h0000_A5A5) begin n_fail++; $display("FAIL bmask_read got %h want 0000a5a5", v); end
        n_checks++; if (gpio_out !== 32'h0000_A5A5) begin n_fail++; $display("FAIL bmask_out got %h want 0000a5a5", gpio_out); end
        n_checks++; if (gpio_oe !== 32'h0) begin n_fail++; $display("FAIL bmask_oe got %h want 0", gpio_oe); end
    endtask

    task automatic test_set_clr;
        logic [31:0] v;
        wr(5'h00, 32'h0F0F_0000, 4'hF);
        wr(5'h18, 32'h0000_00FF, 4'hF);
        wr(5'h1C, 32'h0000_000F, 4'hF);
        n_checks++; if (gpio_out !== 32'h0F0F_00F0) begin n_fail++; $display("FAIL setclr_out got %h want 0f0f00f0", gpio_out); end
        wr(5'h18, 32'hFF00_0000, 4'b0111);
        n_checks++; if (gpio_out !== 32'h0F0F_00F0) begin n_fail++; $display("FAIL set_masked got %h want 0f0f00f0", gpio_out); end
        rd(5'h18, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL set_read got %h want 0", v); end
        rd(5'h1C, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL clr_read got %h want 0", v); end
        wr(5'h04, 32'h0000_FFFF, 4'hF);
        n_checks++; if (gpio_oe !== 32'h0000_FFFF) begin n_fail++; $display("FAIL dir_oe got %h want 0000ffff", gpio_oe); end
    endtask

    task automatic test_edge_irq;
        logic [31:0] v;
        wr(5'h10, 32'h8, 4'hF);
        wr(5'h0C, 32'h8, 4'hF);
        @(negedge clk);
        gpio_in[3] = 1;
        for (int c = 1; c <= SYNC + 1; c++) begin
            @(posedge clk);
            #1;
            n_checks++; if (irq !== (c == SYNC + 1)) begin n_fail++; $display("FAIL edge_irq_c%0d got %b want %b", c, irq, c == SYNC + 1); end
            rd(5'h08, v);
            n_checks++; if (v !== ((c >= SYNC) ? 32'h8 : 32'h0)) begin n_fail++; $display("FAIL edge_in_c%0d got %h", c, v); end
        end
        rd(5'h14, v);
        n_checks++; if (v !== 32'h8) begin n_fail++; $display("FAIL edge_status got %h want 8", v); end
        wr(5'h14, 32'h8, 4'hF);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %b want 0", irq); end
        rd(5'h14, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_status got %h want 0", v); end
    endtask

    task automatic test_w1c_collision;
        logic [31:0] v;
        @(negedge clk);
        gpio_in[0] = 1;
        cycles(SYNC + 3);
        rd(5'h14, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rise_ignored got %h want 0", v); end
        @(negedge clk);
        gpio_in[0] = 0;
        repeat (SYNC) @(posedge clk);
        wr(5'h14, 32'h1, 4'hF);
        rd(5'h14, v);
        n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL set_wins got %h want 1", v); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL set_wins_irq got %b want 0", irq); end
        wr(5'h14, 32'h1, 4'hF);
        rd(5'h14, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_after got %h want 0", v); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(5'h10, 32'hFFFF_FFFF, 4'hF);
        wr(5'h0C, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        gpio_in = 0;
        cycles(SYNC + 3);
        wr(5'h14, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        gpio_in = 32'hFFFF_FFFF;
        cycles(SYNC + 2);
        rd(5'h14, v);
        n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL all_pending got %h want ffffffff", v); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL all_irq got %b want 1", irq); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq got %b want 0", irq); end
        n_checks++; if (gpio_out !== 32'h0 || gpio_oe !== 32'h0) begin n_fail++; $display("FAIL rstmid_pins got %h/%h want 0/0", gpio_out, gpio_oe); end
        for (int a = 3; a < 6; a++) begin
            rd(5'(a * 4), v);
            n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg%0d got %h want 0", a, v); end
        end
        cycles(SYNC + 4);
        rd(5'h14, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL no_spurious got %h want 0", v); end
        rd(5'h08, v);
        n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL in_high got %h want ffffffff", v); end
    endtask

    task automatic test_random;
        logic [31:0] exp;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom % 64) != 0;
            sel = ($urandom % 4) != 0;
            we = $urandom % 2;
            re = $urandom % 2;
            addr = 5'($urandom);
            wdata = $urandom;
            byte_mask = 4'($urandom);
            if ($urandom % 3 == 0) gpio_in = gpio_in ^ ($urandom & $urandom & $urandom);
            #1;
            exp = (sel && re) ? mdl_read(addr[4:2]) : 32'h0;
            n_checks++; if (rdata !== exp) begin n_fail++; $display("FAIL rand_rdata it%0d a=%h got %h want %h", n, addr, rdata, exp); end
            @(posedge clk);
            #1;
            n_checks++; if (gpio_out !== m_out) begin n_fail++; $display("FAIL rand_out it%0d got %h want %h", n, gpio_out, m_out); end
            n_checks++; if (gpio_oe !== m_dir) begin n_fail++; $display("FAIL rand_oe it%0d got %h want %h", n, gpio_oe, m_dir); end
            n_checks++; if (irq !== |(m_status & m_ie)) begin n_fail++; $display("FAIL rand_irq it%0d got %b want %b", n, irq, |(m_status & m_ie)); end
        end
        sel = 0; we = 0; re = 0; rst = 1;
    endtask

    initial begin
        test_reset;
        test_byte_mask;
        test_set_clr;
        test_edge_irq;
        test_w1c_collision;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
